npu_axil_csr: RTL and testbench

AXI4-Lite responder implementing the NPU control/status register map; the host CPU is the initiator. Decodes 32-bit register accesses at offsets 0x00–0x34. Drives configuration values and one-cycle START/SOFT_RESET pulses into the NPU sequencer. Collects busy/done/error from the core into STATUS.

---
 rtl/npu_pkg.sv | 50 +++++
 rtl/npu_axil_csr.sv | 195 +++++++++++++++++++
 tb/tb_npu_axil_csr.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: CSR offsets, CTRL/STATUS bit indices, reset
// defaults for the tiny model configuration, AXI response codes and the
// write-channel state encoding used by npu_axil_csr.
package npu_pkg;

    localparam int NUM_CFG_REGS = 12;

    // Byte offsets inside the CSR window
    localparam logic [5:0] REG_CTRL           = 6'h00;
    localparam logic [5:0] REG_STATUS         = 6'h04;
    localparam logic [5:0] REG_CFG_BASE       = 6'h08;
    localparam logic [5:0] REG_MODEL_HIDDEN   = 6'h20;
    localparam logic [5:0] REG_MODEL_HEADS    = 6'h24;
    localparam logic [5:0] REG_MODEL_HEAD_DIM = 6'h28;
    localparam logic [5:0] REG_SEQ_LEN        = 6'h2C;

    localparam int CTRL_START      = 0;
    localparam int CTRL_SOFT_RESET = 1;

    localparam int STATUS_DONE  = 0;
    localparam int STATUS_BUSY  = 1;
    localparam int STATUS_ERROR = 2;

    localparam logic [31:0] TINY_HIDDEN   = 32'd64;
    localparam logic [31:0] TINY_HEADS    = 32'd4;
    localparam logic [31:0] TINY_HEAD_DIM = 32'd16;
    localparam logic [31:0] TINY_SEQ_LEN  = 32'd8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR_HELD,
        W_DATA_HELD,
        W_RESP
    } wr_state_t;

    // Reset value of the config register living at the given byte offset
    function automatic logic [31:0] cfg_reset_val(input logic [5:0] offset);
        case (offset)
            REG_MODEL_HIDDEN:   return TINY_HIDDEN;
            REG_MODEL_HEADS:    return TINY_HEADS;
            REG_MODEL_HEAD_DIM: return TINY_HEAD_DIM;
            REG_SEQ_LEN:        return TINY_SEQ_LEN;
            default:            return '0;
        endcase
    endfunction

endpackage

// File: rtl/npu_axil_csr.sv
// AXI4-Lite CSR responder for the NPU.
//   clk, rst_n          : clock, async active-low reset
//   s_axil_aw*/w*/b*    : write channels (one write outstanding)
//   s_axil_ar*/r*       : read channels (one read outstanding)
//   start_o             : one-cycle START pulse to the sequencer
//   soft_reset_o        : one-cycle soft-reset pulse
//   cfg_o               : packed config registers, index i at offset 0x08+4i
//   core_busy_i         : live busy level, shown in STATUS.busy
//   core_done_i/error_i : pulses that set the sticky STATUS bits
module npu_axil_csr
    import npu_pkg::*;
#(
    parameter int NUM_CFG = NUM_CFG_REGS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [31:0]             s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [31:0]             s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    start_o,
    output logic                    soft_reset_o,
    output logic [NUM_CFG-1:0][31:0] cfg_o,
    input  logic                    core_busy_i,
    input  logic                    core_done_i,
    input  logic                    core_error_i
);

    localparam logic [3:0] LAST_WORD = 4'(NUM_CFG + 1);

    wr_state_t wr_state, wr_next;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [NUM_CFG-1:0][31:0] cfg_q;
    logic done_q, err_q;

    logic aw_fire, w_fire, ar_fire, commit;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb, wr_word, rd_word;
    logic wr_ok, rd_ok;
    logic ctrl_hit, do_srst, start_req, do_start, start_busy;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic unused_addr_lsbs;

    assign s_axil_awready = (wr_state == W_IDLE) || (wr_state == W_DATA_HELD);
    assign s_axil_wready  = (wr_state == W_IDLE) || (wr_state == W_ADDR_HELD);
    assign s_axil_bvalid  = (wr_state == W_RESP);
    assign s_axil_arready = !s_axil_rvalid;
    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid && s_axil_wready;
    assign ar_fire = s_axil_arvalid && s_axil_arready;
    assign cfg_o   = cfg_q;

    // The commit edge is the edge that completes the second handshake, so
    // the write is visible (and bvalid/pulses are high) in the following
    // cycle. Bypass the holders with the live channel when it fires now.
    assign wr_addr = aw_fire ? s_axil_awaddr : aw_addr_q;
    assign wr_data = w_fire ? s_axil_wdata : w_data_q;
    assign wr_strb = w_fire ? s_axil_wstrb : w_strb_q;
    assign wr_word = wr_addr[5:2];
    assign wr_ok   = (wr_addr[31:6] == '0) && (wr_word <= LAST_WORD);
    assign rd_word = s_axil_araddr[5:2];
    assign rd_ok   = (s_axil_araddr[31:6] == '0) && (rd_word <= LAST_WORD);
    assign unused_addr_lsbs = ^{wr_addr[1:0], s_axil_araddr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_state <= W_IDLE;
        else        wr_state <= wr_next;
    end

    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (aw_fire && w_fire) begin
                    wr_next = W_RESP;
                    commit  = 1'b1;
                end else if (aw_fire) begin
                    wr_next = W_ADDR_HELD;
                end else if (w_fire) begin
                    wr_next = W_DATA_HELD;
                end
            end
            W_ADDR_HELD: if (w_fire) begin
                wr_next = W_RESP;
                commit  = 1'b1;
            end
            W_DATA_HELD: if (aw_fire) begin
                wr_next = W_RESP;
                commit  = 1'b1;
            end
            W_RESP: if (s_axil_bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_fire) aw_addr_q <= s_axil_awaddr;
            if (w_fire) begin
                w_data_q <= s_axil_wdata;
                w_strb_q <= s_axil_wstrb;
            end
        end
    end

    // CTRL decode; soft reset takes precedence over START in the same write
    assign ctrl_hit   = commit && wr_ok && (wr_word == REG_CTRL[5:2]) && wr_strb[0];
    assign do_srst    = ctrl_hit && wr_data[CTRL_SOFT_RESET];
    assign start_req  = ctrl_hit && wr_data[CTRL_START] && !wr_data[CTRL_SOFT_RESET];
    assign do_start   = start_req && !core_busy_i;
    assign start_busy = start_req && core_busy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_bresp <= RESP_OKAY;
            start_o      <= 1'b0;
            soft_reset_o <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (commit) s_axil_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            start_o      <= do_start;
            soft_reset_o <= do_srst;
            // Sets take priority over clears
            if (core_done_i)                done_q <= 1'b1;
            else if (do_start || do_srst)   done_q <= 1'b0;
            if (core_error_i || start_busy) err_q <= 1'b1;
            else if (do_srst)               err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG; i++)
                cfg_q[i] <= cfg_reset_val(6'(REG_CFG_BASE + 6'(4 * i)));
        end else if (commit && wr_ok) begin
            for (int i = 0; i < NUM_CFG; i++)
                if (wr_word == 4'(i + 2))
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) cfg_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Read mux sees pre-commit register state, so a read accepted on the
    // commit edge returns the old value.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (!rd_ok) begin
            rd_resp = RESP_SLVERR;
        end else if (rd_word == REG_STATUS[5:2]) begin
            rd_data[STATUS_DONE]  = done_q;
            rd_data[STATUS_BUSY]  = core_busy_i;
            rd_data[STATUS_ERROR] = err_q;
        end else begin
            for (int i = 0; i < NUM_CFG; i++)
                if (rd_word == 4'(i + 2)) rd_data = cfg_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (ar_fire) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data;
            s_axil_rresp  <= rd_resp;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_npu_axil_csr.sv
// Self-checking bench for npu_axil_csr: directed register-map scenarios
// followed by randomized accesses against a behavioural register model.
module tb_npu_axil_csr;
    import npu_pkg::*;

    localparam int NC = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic s_axil_awvalid = 1'b0, s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic s_axil_wvalid = 1'b0, s_axil_wready;
    logic [1:0] s_axil_bresp;
    logic s_axil_bvalid, s_axil_bready = 1'b0;
    logic [31:0] s_axil_araddr = '0;
    logic s_axil_arvalid = 1'b0, s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic s_axil_rvalid, s_axil_rready = 1'b0;
    logic start_o, soft_reset_o;
    logic [NC-1:0][31:0] cfg_o;
    logic core_busy_i = 1'b0, core_done_i = 1'b0, core_error_i = 1'b0;

    always #5 clk = ~clk;

    npu_axil_csr #(.NUM_CFG(NC)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .start_o(start_o), .soft_reset_o(soft_reset_o), .cfg_o(cfg_o),
        .core_busy_i(core_busy_i), .core_done_i(core_done_i), .core_error_i(core_error_i)
    );

    int n_chk = 0, n_err = 0;
    int start_cnt = 0, srst_cnt = 0, b_rises = 0;
    logic b_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse/edge monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (soft_reset_o) srst_cnt++;
        if (s_axil_bvalid && !b_prev) b_rises++;
        b_prev = s_axil_bvalid;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_cfg [NC];
    bit m_done, m_err;

    task automatic m_reset();
        for (int i = 0; i < NC; i++) m_cfg[i] = 32'h0;
        m_cfg[6] = 32'd64;  // 0x20
        m_cfg[7] = 32'd4;   // 0x24
        m_cfg[8] = 32'd16;  // 0x28
        m_cfg[9] = 32'd8;   // 0x2C
        m_done = 0;
        m_err  = 0;
    endtask

    function automatic logic [31:0] m_rdata(input logic [31:0] a, input bit busy);
        int w;
        if (a >= 32'h38) return 32'h0;
        w = int'(a) / 4;
        if (w == 0) return 32'h0;
        if (w == 1) return {29'h0, m_err, busy, m_done};
        return m_cfg[w - 2];
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return (a >= 32'h38) ? 2'b10 : 2'b00;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit busy, output int n_start, output int n_srst);
        int w;
        logic [31:0] mask;
        n_start = 0;
        n_srst  = 0;
        if (a >= 32'h38) return;
        w = int'(a) / 4;
        if (w == 0) begin
            if (s[0]) begin
                if (d[1]) begin
                    n_srst = 1; m_done = 0; m_err = 0;
                end else if (d[0]) begin
                    if (busy) m_err = 1;
                    else begin n_start = 1; m_done = 0; end
                end
            end
        end else if (w >= 2) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
            m_cfg[w - 2] = (m_cfg[w - 2] & ~mask) | (d & mask);
        end
    endtask

    // ---------------- bus tasks ----------------
    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int aw_dly, input int w_dly, input int b_dly, input bit done_pulse,
                              output logic [1:0] resp);
        bit aw_done = 0, w_done = 0;
        int cyc = 0;
        s_axil_awaddr = addr;
        s_axil_wdata  = data;
        s_axil_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 100) begin
            bit aw_hs, w_hs;
            s_axil_awvalid = !aw_done && cyc >= aw_dly;
            s_axil_wvalid  = !w_done && cyc >= w_dly;
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            // done pulse spans the completing handshake cycle and the next one
            if (done_pulse && (aw_done || aw_hs) && (w_done || w_hs)) core_done_i = 1'b1;
            @(posedge clk); @(negedge clk);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        chk("wr_hs_timeout", 32'(!(aw_done && w_done)), 32'h0);
        chk("bvalid_commit", 32'(s_axil_bvalid), 32'h1);
        resp = s_axil_bresp;
        if (done_pulse) begin
            @(posedge clk); @(negedge clk);
            core_done_i = 1'b0;
        end
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); @(negedge clk);
            chk("b_hold", {29'h0, s_axil_bvalid, s_axil_bresp}, {29'h0, 1'b1, resp});
            chk("aw_blocked", 32'(s_axil_awready), 32'h0);
        end
        s_axil_bready = 1'b1;
        @(posedge clk); @(negedge clk);
        s_axil_bready = 1'b0;
        chk("b_done", {30'h0, s_axil_bvalid, s_axil_awready}, 32'h1);
    endtask

    task automatic axil_read(input logic [31:0] addr, input int r_dly,
                             output logic [31:0] data, output logic [1:0] resp);
        int cyc = 0;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && cyc < 100) begin
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        chk("ar_timeout", 32'(cyc >= 100), 32'h0);
        @(posedge clk); @(negedge clk);
        s_axil_arvalid = 1'b0;
        chk("rvalid_t1", 32'(s_axil_rvalid), 32'h1);
        data = s_axil_rdata;
        resp = s_axil_rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); @(negedge clk);
            chk("r_hold", s_axil_rdata, data);
            chk("ar_blocked", 32'(s_axil_arready), 32'h0);
        end
        s_axil_rready = 1'b1;
        @(posedge clk); @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    task automatic pulse(input bit err);
        if (err) core_error_i = 1'b1; else core_done_i = 1'b1;
        @(posedge clk); @(negedge clk);
        core_error_i = 1'b0;
        core_done_i  = 1'b0;
        if (err) m_err = 1; else m_done = 1;
    endtask

    task automatic chk_cfg(input string tag);
        for (int i = 0; i < NC; i++) chk(tag, cfg_o[i], m_cfg[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        int s0, r0, b0, ns, nr;

        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h7);
        chk("rst_valid", {28'h0, s_axil_bvalid, s_axil_rvalid, start_o, soft_reset_o}, 32'h0);
        chk_cfg("rst_cfg");
        rst_n = 1'b1;
        @(negedge clk);

        axil_read(32'h20, 0, rd, rr);
        chk("rd_hidden", {rd[29:0], rr}, {32'h40 << 2});
        axil_read(32'h2C, 1, rd, rr);
        chk("rd_seq_len", rd, 32'h8);
        axil_read(32'h00, 0, rd, rr);
        chk("rd_ctrl", rd, 32'h0);

        // Partial-strobe write, W leads AW by 3 cycles
        b0 = b_rises;
        axil_write(32'h10, 32'hDEADBEEF, 4'b0101, 3, 0, 2, 0, br);
        m_write(32'h10, 32'hDEADBEEF, 4'b0101, 0, ns, nr);
        chk("strb_bresp", 32'(br), 32'h0);
        chk("strb_bcount", 32'(b_rises - b0), 32'h1);
        chk("strb_cfg", cfg_o[2], 32'h00AD00EF);
        axil_read(32'h10, 0, rd, rr);
        chk("strb_rd", rd, 32'h00AD00EF);

        // START when idle, done sticky, restart clears done
        core_busy_i = 1'b0;
        s0 = start_cnt;
        axil_write(32'h00, 32'h1, 4'hF, 0, 0, 0, 0, br);
        chk("start_pulse", 32'(start_cnt - s0), 32'h1);
        pulse(0);
        axil_read(32'h04, 0, rd, rr);
        chk("status_done", rd, 32'h1);
        axil_write(32'h00, 32'h1, 4'hF, 1, 0, 0, 0, br);
        axil_read(32'h04, 0, rd, rr);
        chk("status_done_clr", rd, 32'h0);

        // START while busy -> error; soft reset clears
        core_busy_i = 1'b1;
        s0 = start_cnt; r0 = srst_cnt;
        axil_write(32'h00, 32'h1, 4'hF, 0, 0, 0, 0, br);
        chk("busy_start_resp", 32'(br), 32'h0);
        chk("busy_no_start", 32'(start_cnt - s0), 32'h0);
        axil_read(32'h04, 0, rd, rr);
        chk("status_busy_err", rd, 32'h6);
        axil_write(32'h00, 32'h2, 4'hF, 0, 2, 0, 0, br);
        chk("srst_pulse", 32'(srst_cnt - r0), 32'h1);
        axil_read(32'h04, 0, rd, rr);
        chk("status_after_srst", rd, 32'h2);
        core_busy_i = 1'b0;
        m_reset();
        m_cfg[2] = 32'h00AD00EF;
        chk_cfg("srst_keeps_cfg");

        // Both control bits: soft reset only
        s0 = start_cnt; r0 = srst_cnt;
        axil_write(32'h00, 32'h3, 4'hF, 0, 0, 0, 0, br);
        chk("both_bits", {16'(start_cnt - s0), 16'(srst_cnt - r0)}, {16'h0, 16'h1});

        // START with done arriving around the commit: set wins
        axil_write(32'h00, 32'h1, 4'hF, 0, 0, 0, 1, br);
        m_done = 1;
        axil_read(32'h04, 0, rd, rr);
        chk("done_set_wins", rd, 32'h1);

        // Unmapped accesses
        axil_read(32'h38, 0, rd, rr);
        chk("unmapped_rd", {rd[29:0], rr}, {30'h0, 2'b10});
        axil_write(32'h100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 0, br);
        chk("unmapped_bresp", 32'(br), 32'h2);
        chk_cfg("unmapped_cfg");

        // Randomized traffic against the model
        for (int k = 0; k < 80; k++) begin
            int op, sel;
            logic [31:0] a, d;
            logic [3:0] s;
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 32'h8 + 32'(4 * $urandom_range(0, 11)) + 32'($urandom_range(0, 3));
            else if (sel == 6) a = 32'h0;
            else if (sel == 7) a = 32'h4;
            else if (sel == 8) a = 32'h38 + 32'(4 * $urandom_range(0, 17));
            else               a = $urandom;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            core_busy_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (op < 5) begin
                s0 = start_cnt; r0 = srst_cnt;
                axil_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0, br);
                m_write(a, d, s, core_busy_i, ns, nr);
                chk("rnd_bresp", 32'(br), 32'(m_resp(a)));
                chk("rnd_pulses", {16'(start_cnt - s0), 16'(srst_cnt - r0)}, {16'(ns), 16'(nr)});
            end else if (op < 9) begin
                axil_read(a, $urandom_range(0, 2), rd, rr);
                chk("rnd_rdata", rd, m_rdata(a, core_busy_i));
                chk("rnd_rresp", 32'(rr), 32'(m_resp(a)));
            end else begin
                pulse($urandom_range(0, 1) == 1);
            end
        end
        core_busy_i = 1'b0;
        chk_cfg("rnd_cfg");

        // Concurrent write+read with both response channels stalled, then reset
        @(negedge clk);
        s_axil_awaddr = 32'h0C; s_axil_wdata = 32'h1234_5678; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        s_axil_araddr = 32'h0C; s_axil_arvalid = 1'b1;
        rd = m_cfg[1];
        @(posedge clk); @(negedge clk);
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        m_cfg[1] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {30'h0, s_axil_bvalid, s_axil_rvalid}, 32'h3);
            chk("stall_rdata", s_axil_rdata, rd);
            chk("stall_ready", {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h0);
            chk("stall_cfg", cfg_o[1], 32'h1234_5678);
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_ready", {29'h0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'h7);
        chk("arst_valid", {28'h0, s_axil_bvalid, s_axil_rvalid, start_o, soft_reset_o}, 32'h0);
        chk("arst_data", s_axil_rdata, 32'h0);
        chk("arst_resp", {28'h0, s_axil_bresp, s_axil_rresp}, 32'h0);
        chk_cfg("arst_cfg");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_b", 32'(s_axil_bvalid), 32'h0);
        axil_read(32'h24, 0, rd, rr);
        chk("post_rst_heads", rd, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
